// File: rtl/bankregister_param_if.sv
// Register bank access bundle: two read ports, two write ports and the
// scoreboard reserve channel, plus the busy/conflict status back to the core.
interface bankregister_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  // read ports
  logic [ADDR_W-1:0] RegLe1;
  logic [ADDR_W-1:0] RegLe2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  // write port A
  logic [ADDR_W-1:0] RegEscr;
  logic              EscrReg;
  logic [DATA_W-1:0] datain;
  // write port B
  logic [ADDR_W-1:0] RegEscr2;
  logic              EscrReg2;
  logic [DATA_W-1:0] datain2;
  // scoreboard reserve
  logic [ADDR_W-1:0] RegRes;
  logic              ResReg;
  // status
  logic              busy1;
  logic              busy2;
  logic              wr_conflict;

  // core side: drives addresses, write data and reserves
  modport master (
    output RegLe1, RegLe2, RegEscr, EscrReg, datain,
           RegEscr2, EscrReg2, datain2, RegRes, ResReg,
    input  data1, data2, busy1, busy2, wr_conflict
  );

  // register bank side
  modport slave (
    input  RegLe1, RegLe2, RegEscr, EscrReg, datain,
           RegEscr2, EscrReg2, datain2, RegRes, ResReg,
    output data1, data2, busy1, busy2, wr_conflict
  );
endinterface

// File: rtl/bankregister_param.sv
// Parametrised register bank: two combinational read ports with optional
// write-to-read forwarding, two write ports (port B wins on collision),
// optional hardwired zero register and a per-register busy scoreboard.
module bankregister_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  bankregister_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NRD   = 2;

  // write / reserve request aliases
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] waddr_a;
  logic [ADDR_W-1:0] waddr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              res_en;
  logic [ADDR_W-1:0] res_addr;

  assign we_a     = bus.EscrReg;
  assign we_b     = bus.EscrReg2;
  assign waddr_a  = bus.RegEscr;
  assign waddr_b  = bus.RegEscr2;
  assign wdata_a  = bus.datain;
  assign wdata_b  = bus.datain2;
  assign res_en   = bus.ResReg;
  assign res_addr = bus.RegRes;

  // flattened view of the storage and scoreboard for the read muxes
  logic [DATA_W-1:0] regs     [DEPTH];
  logic              busy_vec [DEPTH];

  // one storage slot and one busy bit per register
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (ZERO_REG && (gi == 0)) begin : g_zero
      // hardwired zero: writes and reserves are dropped, never busy
      assign regs[gi]     = '0;
      assign busy_vec[gi] = 1'b0;
    end else begin : g_live
      logic [DATA_W-1:0] q_reg;
      logic [DATA_W-1:0] q_next;
      logic              busy_reg;
      logic              busy_next;
      logic              hit_a;
      logic              hit_b;
      logic              hit_res;

      assign hit_a   = we_a   && (waddr_a  == ADDR_W'(gi));
      assign hit_b   = we_b   && (waddr_b  == ADDR_W'(gi));
      assign hit_res = res_en && (res_addr == ADDR_W'(gi));

      // next data: port B has priority over port A on the same slot
      always_comb begin
        q_next = q_reg;
        if (hit_b) begin
          q_next = wdata_b;
        end else if (hit_a) begin
          q_next = wdata_a;
        end
      end

      // next busy: a reserve marks a newer producer, so it beats a write-clear
      always_comb begin
        busy_next = busy_reg;
        if (hit_res) begin
          busy_next = 1'b1;
        end else if (hit_a || hit_b) begin
          busy_next = 1'b0;
        end
      end

      // register slot and busy bit update
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_reg    <= '0;
          busy_reg <= 1'b0;
        end else begin
          q_reg    <= q_next;
          busy_reg <= busy_next;
        end
      end

      assign regs[gi]     = q_reg;
      assign busy_vec[gi] = busy_reg;
    end
  end

  // collision flag for the cycle after both ports targeted one address
  logic wr_conflict_reg;
  logic wr_conflict_next;

  assign wr_conflict_next = we_a && we_b && (waddr_a == waddr_b);

  // conflict flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_conflict_reg <= 1'b0;
    end else begin
      wr_conflict_reg <= wr_conflict_next;
    end
  end

  assign bus.wr_conflict = wr_conflict_reg;

  // read ports share one mux structure, indexed by port number
  logic [ADDR_W-1:0] rd_addr [NRD];
  logic [DATA_W-1:0] rd_data [NRD];
  logic              rd_busy [NRD];

  assign rd_addr[0] = bus.RegLe1;
  assign rd_addr[1] = bus.RegLe2;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic fwd_a;
    logic fwd_b;
    logic is_zero;

    assign fwd_a   = BYPASS && we_a && (waddr_a == rd_addr[gi]);
    assign fwd_b   = BYPASS && we_b && (waddr_b == rd_addr[gi]);
    assign is_zero = ZERO_REG && (rd_addr[gi] == '0);

    // data select: zero register first, then forwarding (B over A), then array
    always_comb begin
      rd_data[gi] = regs[rd_addr[gi]];
      if (is_zero) begin
        rd_data[gi] = '0;
      end else if (fwd_b) begin
        rd_data[gi] = wdata_b;
      end else if (fwd_a) begin
        rd_data[gi] = wdata_a;
      end
    end

    // busy select: a forwarded value is already available, so not busy
    always_comb begin
      rd_busy[gi] = busy_vec[rd_addr[gi]];
      if (fwd_a || fwd_b) begin
        rd_busy[gi] = 1'b0;
      end
    end
  end

  assign bus.data1 = rd_data[0];
  assign bus.data2 = rd_data[1];
  assign bus.busy1 = rd_busy[0];
  assign bus.busy2 = rd_busy[1];

endmodule

// File: tb/tb_bankregister_param.sv
// Directed bench for bankregister_param: one instance with the zero register
// and forwarding enabled, one with both disabled, driven with the same inputs.
module tb_bankregister_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  logic clk;
  logic reset;

  bankregister_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  bankregister_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

  bankregister_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  bankregister_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_nb (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  // second instance mirrors the stimulus applied to the first
  assign bus_b.RegLe1   = bus_a.RegLe1;
  assign bus_b.RegLe2   = bus_a.RegLe2;
  assign bus_b.RegEscr  = bus_a.RegEscr;
  assign bus_b.EscrReg  = bus_a.EscrReg;
  assign bus_b.datain   = bus_a.datain;
  assign bus_b.RegEscr2 = bus_a.RegEscr2;
  assign bus_b.EscrReg2 = bus_a.EscrReg2;
  assign bus_b.datain2  = bus_a.datain2;
  assign bus_b.RegRes   = bus_a.RegRes;
  assign bus_b.ResReg   = bus_a.ResReg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic idle();
    bus_a.EscrReg  = 1'b0;
    bus_a.EscrReg2 = 1'b0;
    bus_a.ResReg   = 1'b0;
    bus_a.RegEscr  = '0;
    bus_a.RegEscr2 = '0;
    bus_a.RegRes   = '0;
    bus_a.datain   = '0;
    bus_a.datain2  = '0;
  endtask

  // advance to just past the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus_a.RegLe1 = 6'd0;
    bus_a.RegLe2 = 6'd1;
    cyc();
    cyc();
    check("rst_conflict_during", {31'b0, bus_a.wr_conflict}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_data1", bus_a.data1, 32'h0);
    check("rst_data2", bus_a.data2, 32'h0);
    check("rst_busy1", {31'b0, bus_a.busy1}, 32'h0);
    check("rst_busy2", {31'b0, bus_a.busy2}, 32'h0);
    check("rst_nb_data2", bus_b.data2, 32'h0);

    // write reg 5, then assert reset asynchronously mid-cycle
    cyc();
    bus_a.EscrReg = 1'b1; bus_a.RegEscr = 6'd5; bus_a.datain = 32'h1234;
    bus_a.ResReg = 1'b1; bus_a.RegRes = 6'd6;
    cyc();
    idle();
    bus_a.RegLe1 = 6'd5; bus_a.RegLe2 = 6'd6;
    #1;
    check("wr5_data1", bus_a.data1, 32'h1234);
    check("wr5_nb_data1", bus_b.data1, 32'h1234);
    check("res6_busy2", {31'b0, bus_a.busy2}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_data1", bus_a.data1, 32'h0);
    check("async_rst_nb_data1", bus_b.data1, 32'h0);
    check("async_rst_busy2", {31'b0, bus_a.busy2}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // write with forwarding vs without
    cyc();
    bus_a.EscrReg = 1'b1; bus_a.RegEscr = 6'd3; bus_a.datain = 32'hDEADBEEF;
    bus_a.RegLe1 = 6'd3;
    #1;
    check("byp_same_cycle", bus_a.data1, 32'hDEADBEEF);
    check("nobyp_same_cycle", bus_b.data1, 32'h0);
    cyc();
    idle();
    #1;
    check("byp_after_edge", bus_a.data1, 32'hDEADBEEF);
    check("nobyp_after_edge", bus_b.data1, 32'hDEADBEEF);

    // both ports on reg 7: port B wins, conflict flag for one cycle
    bus_a.EscrReg  = 1'b1; bus_a.RegEscr  = 6'd7; bus_a.datain  = 32'h1;
    bus_a.EscrReg2 = 1'b1; bus_a.RegEscr2 = 6'd7; bus_a.datain2 = 32'h2;
    bus_a.RegLe1 = 6'd7;
    #1;
    check("conf_byp_b_prio", bus_a.data1, 32'h2);
    check("conf_before", {31'b0, bus_a.wr_conflict}, 32'h0);
    cyc();
    idle();
    #1;
    check("conf_data", bus_a.data1, 32'h2);
    check("conf_nb_data", bus_b.data1, 32'h2);
    check("conf_flag", {31'b0, bus_a.wr_conflict}, 32'h1);
    cyc();
    check("conf_flag_clear", {31'b0, bus_a.wr_conflict}, 32'h0);

    // different addresses: both stored, no conflict
    bus_a.EscrReg  = 1'b1; bus_a.RegEscr  = 6'd7; bus_a.datain  = 32'h77;
    bus_a.EscrReg2 = 1'b1; bus_a.RegEscr2 = 6'd8; bus_a.datain2 = 32'h88;
    bus_a.RegLe1 = 6'd7; bus_a.RegLe2 = 6'd8;
    cyc();
    idle();
    #1;
    check("dual_data1", bus_a.data1, 32'h77);
    check("dual_data2", bus_a.data2, 32'h88);
    check("dual_conflict", {31'b0, bus_a.wr_conflict}, 32'h0);

    // register 0: write and reserve
    bus_a.EscrReg = 1'b1; bus_a.RegEscr = 6'd0; bus_a.datain = 32'hFFFF;
    bus_a.ResReg  = 1'b1; bus_a.RegRes  = 6'd0;
    bus_a.RegLe1 = 6'd0;
    #1;
    check("zero_byp_data1", bus_a.data1, 32'h0);
    check("zero_busy1_during", {31'b0, bus_a.busy1}, 32'h0);
    cyc();
    idle();
    #1;
    check("zero_data1", bus_a.data1, 32'h0);
    check("zero_busy1", {31'b0, bus_a.busy1}, 32'h0);
    check("nozero_data1", bus_b.data1, 32'hFFFF);
    check("nozero_busy1", {31'b0, bus_b.busy1}, 32'h1);

    // scoreboard on reg 4
    bus_a.ResReg = 1'b1; bus_a.RegRes = 6'd4;
    bus_a.RegLe1 = 6'd4; bus_a.RegLe2 = 6'd4;
    cyc();
    idle();
    #1;
    check("sb_busy1", {31'b0, bus_a.busy1}, 32'h1);
    check("sb_busy2_same_reg", {31'b0, bus_a.busy2}, 32'h1);
    bus_a.EscrReg = 1'b1; bus_a.RegEscr = 6'd4; bus_a.datain = 32'h44;
    #1;
    check("sb_byp_busy1", {31'b0, bus_a.busy1}, 32'h0);
    check("sb_nobyp_busy1", {31'b0, bus_b.busy1}, 32'h1);
    cyc();
    idle();
    #1;
    check("sb_cleared", {31'b0, bus_a.busy1}, 32'h0);
    check("sb_cleared_data", bus_a.data1, 32'h44);
    bus_a.ResReg = 1'b1; bus_a.RegRes = 6'd4;
    bus_a.EscrReg2 = 1'b1; bus_a.RegEscr2 = 6'd4; bus_a.datain2 = 32'h45;
    cyc();
    idle();
    #1;
    check("sb_res_wins", {31'b0, bus_a.busy1}, 32'h1);
    check("sb_res_wins_data", bus_a.data1, 32'h45);
    bus_a.ResReg = 1'b1; bus_a.RegRes = 6'd4;
    cyc();
    idle();
    #1;
    check("sb_res_on_busy", {31'b0, bus_a.busy1}, 32'h1);
    bus_a.EscrReg = 1'b1; bus_a.RegEscr = 6'd4; bus_a.datain = 32'h46;
    cyc();
    idle();
    #1;
    check("sb_final_clear", {31'b0, bus_a.busy1}, 32'h0);
    check("sb_final_nb_clear", {31'b0, bus_b.busy1}, 32'h0);
    check("sb_final_data", bus_b.data1, 32'h46);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
